rflp_sram_gen: RTL and testbench

//  Parametrised single-port synchronous register-file SRAM; successor to the fixed 1024x21 macro model.

---
 rtl/rflp_sram_pkg.sv | 33 +++
 rtl/rflp_sram_clr_seq.sv | 63 ++++++
 rtl/rflp_sram_gen.sv | 168 ++++++++++++++++
 tb/tb_rflp_sram_gen.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/rflp_sram_pkg.sv
// Shared types and helpers for the parametrised register-file SRAM.
// Holds the sequencer state type, lane count and per-lane mask expansion.
package rflp_sram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    // Widest word the mask helper can expand; the top slices it down to DATA_W.
    localparam int MAX_W     = 64;
    localparam int MAX_IDX_W = $clog2(MAX_W);

    function automatic int lanes(input int data_w, input int lane_w);
        return (data_w + lane_w - 1) / lane_w;
    endfunction

    // Expands active-low lane enables into an active-high per-bit write mask.
    function automatic logic [MAX_W-1:0] lane_mask(input logic [MAX_W-1:0] nbwe,
                                                   input int               lane_w);
        logic [MAX_W-1:0]     m;
        logic [MAX_IDX_W-1:0] bi;
        logic [MAX_IDX_W-1:0] li;
        m = '0;
        for (int b = 0; b < MAX_W; b++) begin
            bi    = MAX_IDX_W'(b);
            li    = MAX_IDX_W'(b / lane_w);
            m[bi] = ~nbwe[li];
        end
        return m;
    endfunction

endpackage

// File: rtl/rflp_sram_clr_seq.sv
// Memory-clear sequencer: sweeps INIT_VAL through every address after reset
// and holds BUSY until the last word has been written.
module rflp_sram_clr_seq
    import rflp_sram_pkg::*;
#(
    parameter int                ADDR_W       = 10,
    parameter int                DATA_W       = 21,
    parameter int                CLEAR_ON_RST = 1,
    parameter logic [DATA_W-1:0] INIT_VAL     = '0
) (
    input  logic              clk,
    input  logic              srst,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic [DATA_W-1:0] clr_data
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state_reg;
    state_t            state_next;
    logic [ADDR_W-1:0] cnt_reg;
    logic [ADDR_W-1:0] cnt_next;

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg <= (CLEAR_ON_RST != 0) ? CLEAR : IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        clr_we     = 1'b0;
        case (state_reg)
            CLEAR: begin
                // No writes while reset is held; the sweep starts on the first free edge.
                clr_we = ~srst;
                if (cnt_reg == LAST_ADDR) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + ADDR_W'(1);
                end
            end
            IDLE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy     = (state_reg == CLEAR);
    assign clr_addr = cnt_reg;
    assign clr_data = INIT_VAL;

endmodule

// File: rtl/rflp_sram_gen.sv
// Parametrised single-port register-file SRAM with lane write masks,
// 1- or 2-cycle read latency, optional write-through and a reset clear sweep.
module rflp_sram_gen
    import rflp_sram_pkg::*;
#(
    parameter int                DATA_W       = 21,
    parameter int                RA_W         = 8,
    parameter int                CA_W         = 2,
    parameter int                LANE_W       = 8,
    parameter int                READ_LAT     = 1,
    parameter int                WRITE_THRU   = 0,
    parameter int                CLEAR_ON_RST = 1,
    parameter logic [DATA_W-1:0] INIT_VAL     = '0,
    localparam int               LANES        = lanes(DATA_W, LANE_W)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              NCE,
    input  logic              NWRT,
    input  logic [RA_W-1:0]   RA,
    input  logic [CA_W-1:0]   CA,
    input  logic [DATA_W-1:0] DIN,
    input  logic [LANES-1:0]  NBWE,
    output logic [DATA_W-1:0] DO,
    output logic              DOV,
    output logic              BUSY,
    output logic              REJ
);

    localparam int ADDR_W = RA_W + CA_W;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              busy;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic [DATA_W-1:0] clr_data;

    logic [ADDR_W-1:0] addr;
    logic              acc_ok;
    logic              wr_acc;
    logic              rd_acc;
    logic              load;
    logic [DATA_W-1:0] user_mask;

    logic              w_en;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic [LANES-1:0]  w_lane_en;

    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] din_reg;
    logic [DATA_W-1:0] mask_reg;
    logic              s1_valid_reg;
    logic [DATA_W-1:0] s1_word;
    logic              rej_reg;

    rflp_sram_clr_seq #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .CLEAR_ON_RST (CLEAR_ON_RST),
        .INIT_VAL     (INIT_VAL)
    ) u_clr_seq (
        .clk      (CLK),
        .srst     (RST),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .clr_data (clr_data)
    );

    assign addr      = {RA, CA};
    assign acc_ok    = ~NCE & ~busy & ~RST;
    assign wr_acc    = acc_ok & (NWRT == 1'b0);
    assign rd_acc    = acc_ok & (NWRT == 1'b1);
    // Write-through reuses the read path: the old word is read and merged one stage later.
    assign load      = rd_acc | (wr_acc & (WRITE_THRU != 0));
    assign user_mask = DATA_W'(lane_mask(MAX_W'(NBWE), LANE_W));

    always_comb begin
        w_en      = 1'b0;
        w_addr    = addr;
        w_data    = DIN;
        w_lane_en = ~NBWE;
        if (clr_we) begin
            w_en      = 1'b1;
            w_addr    = clr_addr;
            w_data    = clr_data;
            w_lane_en = '1;
        end else if (wr_acc) begin
            w_en = 1'b1;
        end
    end

    // One narrow array per lane so each maps onto a block RAM with its own write enable.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            localparam int LO = gi * LANE_W;
            localparam int W  = ((gi + 1) * LANE_W > DATA_W) ? (DATA_W - LO) : LANE_W;

            logic [W-1:0] lane_mem [DEPTH];
            logic [W-1:0] lane_rd_reg;

            always_ff @(posedge CLK) begin
                if (w_en && w_lane_en[gi]) begin
                    lane_mem[w_addr] <= w_data[LO +: W];
                end
            end

            always_ff @(posedge CLK) begin
                if (RST) begin
                    lane_rd_reg <= '0;
                end else if (load) begin
                    lane_rd_reg <= lane_mem[addr];
                end
            end

            assign rd_word[LO +: W] = lane_rd_reg;
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            din_reg      <= '0;
            mask_reg     <= '0;
            s1_valid_reg <= 1'b0;
            rej_reg      <= 1'b0;
        end else begin
            s1_valid_reg <= load;
            rej_reg      <= ~NCE & busy;
            if (load) begin
                din_reg  <= DIN;
                mask_reg <= wr_acc ? user_mask : '0;
            end
        end
    end

    // Reads carry a zero mask, so this is the raw array word for them.
    assign s1_word = (rd_word & ~mask_reg) | (din_reg & mask_reg);

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] do_reg;
            logic              dov_reg;

            always_ff @(posedge CLK) begin
                if (RST) begin
                    do_reg  <= '0;
                    dov_reg <= 1'b0;
                end else begin
                    dov_reg <= s1_valid_reg;
                    if (s1_valid_reg) begin
                        do_reg <= s1_word;
                    end
                end
            end

            assign DO  = do_reg;
            assign DOV = dov_reg;
        end else begin : g_lat1
            assign DO  = s1_word;
            assign DOV = s1_valid_reg;
        end
    endgenerate

    assign BUSY = busy;
    assign REJ  = rej_reg;

endmodule

// File: tb/tb_rflp_sram_gen.sv
// Directed bench for rflp_sram_gen: four instances covering read latency 1/2
// with and without write-through, sharing one stimulus stream.
module tb_rflp_sram_gen;

    localparam logic [20:0] INIT = 21'h0A5A5A;

    logic        CLK = 1'b0;
    logic        RST;
    logic        NCE;
    logic        NWRT;
    logic [7:0]  RA;
    logic [1:0]  CA;
    logic [20:0] DIN;
    logic [2:0]  NBWE;

    logic [20:0] do_w   [4];
    logic        dov_w  [4];
    logic        busy_w [4];
    logic        rej_w  [4];

    int          errors = 0;
    int          checks = 0;
    logic [20:0] exp_do [4];
    logic [20:0] vals   [8];
    int          cnt;

    always #5 CLK = ~CLK;

    // dut0: RL1 WT0, dut1: RL2 WT0, dut2: RL1 WT1, dut3: RL2 WT1
    rflp_sram_gen #(.READ_LAT(1), .WRITE_THRU(0), .CLEAR_ON_RST(1), .INIT_VAL(INIT)) dut0 (
        .CLK(CLK), .RST(RST), .NCE(NCE), .NWRT(NWRT), .RA(RA), .CA(CA), .DIN(DIN), .NBWE(NBWE),
        .DO(do_w[0]), .DOV(dov_w[0]), .BUSY(busy_w[0]), .REJ(rej_w[0]));
    rflp_sram_gen #(.READ_LAT(2), .WRITE_THRU(0), .CLEAR_ON_RST(1), .INIT_VAL(INIT)) dut1 (
        .CLK(CLK), .RST(RST), .NCE(NCE), .NWRT(NWRT), .RA(RA), .CA(CA), .DIN(DIN), .NBWE(NBWE),
        .DO(do_w[1]), .DOV(dov_w[1]), .BUSY(busy_w[1]), .REJ(rej_w[1]));
    rflp_sram_gen #(.READ_LAT(1), .WRITE_THRU(1), .CLEAR_ON_RST(1), .INIT_VAL(INIT)) dut2 (
        .CLK(CLK), .RST(RST), .NCE(NCE), .NWRT(NWRT), .RA(RA), .CA(CA), .DIN(DIN), .NBWE(NBWE),
        .DO(do_w[2]), .DOV(dov_w[2]), .BUSY(busy_w[2]), .REJ(rej_w[2]));
    rflp_sram_gen #(.READ_LAT(2), .WRITE_THRU(1), .CLEAR_ON_RST(1), .INIT_VAL(INIT)) dut3 (
        .CLK(CLK), .RST(RST), .NCE(NCE), .NWRT(NWRT), .RA(RA), .CA(CA), .DIN(DIN), .NBWE(NBWE),
        .DO(do_w[3]), .DOV(dov_w[3]), .BUSY(busy_w[3]), .REJ(rej_w[3]));

    task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d observed=%h expected=%h", tag, idx, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] dov_exp);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_dov"}, i, 32'(dov_w[i]), 32'(dov_exp[i]));
            chk({tag, "_do"}, i, 32'(do_w[i]), 32'(exp_do[i]));
        end
    endtask

    task automatic chk_flag(input string tag, input logic busy_exp, input logic rej_exp);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_busy"}, i, 32'(busy_w[i]), 32'(busy_exp));
            chk({tag, "_rej"}, i, 32'(rej_w[i]), 32'(rej_exp));
        end
    endtask

    task automatic rd(input logic [9:0] a, input logic [20:0] v);
        NCE = 1'b0; NWRT = 1'b1; {RA, CA} = a;
        tick();
        NCE = 1'b1;
        exp_do[0] = v; exp_do[2] = v;
        chk_out("rd_lat1", 4'b0101);
        tick();
        exp_do[1] = v; exp_do[3] = v;
        chk_out("rd_lat2", 4'b1010);
        $display("read  addr=%03h exp=%06h do=%06h/%06h/%06h/%06h", a, v, do_w[0], do_w[1], do_w[2], do_w[3]);
    endtask

    task automatic wr(input logic [9:0] a, input logic [20:0] d, input logic [2:0] nb, input logic [20:0] merged);
        NCE = 1'b0; NWRT = 1'b0; {RA, CA} = a; DIN = d; NBWE = nb;
        tick();
        NCE = 1'b1; NWRT = 1'b1; NBWE = 3'b111;
        exp_do[2] = merged;
        chk_out("wr_lat1", 4'b0100);
        tick();
        exp_do[3] = merged;
        chk_out("wr_lat2", 4'b1000);
        $display("write addr=%03h din=%06h nbwe=%03b merged=%06h", a, d, nb, merged);
    endtask

    task automatic sweep(input int limit, input bit inject_rej);
        cnt = 0;
        while (busy_w[0] && cnt < limit) begin
            if (inject_rej && cnt == 100) begin
                NCE = 1'b0; NWRT = 1'b0; {RA, CA} = 10'd5; DIN = 21'h00FF00; NBWE = 3'b000;
            end else begin
                NCE = 1'b1; NWRT = 1'b1; NBWE = 3'b111;
            end
            tick();
            cnt++;
            if (inject_rej && cnt == 101) begin
                chk_flag("rej_pulse", 1'b1, 1'b1);
                chk_out("rej_nodov", 4'b0000);
            end
            if (inject_rej && cnt == 102) chk_flag("rej_end", 1'b1, 1'b0);
        end
        $display("sweep busy_cycles=%0d", cnt);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; NCE = 1'b1; NWRT = 1'b1; RA = '0; CA = '0; DIN = '0; NBWE = 3'b111;
        for (int i = 0; i < 4; i++) exp_do[i] = '0;
        tick();
        chk_out("reset", 4'b0000);
        chk_flag("reset", 1'b1, 1'b0);

        // Initial clear sweep and boundary reads
        RST = 1'b0;
        sweep(2000, 1'b0);
        chk("sweep_len", 0, 32'(cnt), 32'd1024);
        chk_flag("sweep_done", 1'b0, 1'b0);
        rd(10'd0, INIT);
        rd(10'd511, INIT);
        rd(10'd1023, INIT);

        // Full-word write and readback at {RA=12,CA=2}
        wr(10'h04A, 21'h1ABCDE, 3'b000, 21'h1ABCDE);
        rd(10'h04A, 21'h1ABCDE);

        // Lane masking: only the middle lane is written
        wr(10'h155, 21'h1FFFFF, 3'b000, 21'h1FFFFF);
        wr(10'h155, 21'h000000, 3'b101, 21'h1F00FF);
        rd(10'h155, 21'h1F00FF);
        wr(10'h155, 21'h000000, 3'b111, 21'h1F00FF);
        rd(10'h155, 21'h1F00FF);

        // Write-through of a small value
        wr(10'h300, 21'h000055, 3'b000, 21'h000055);
        rd(10'h300, 21'h000055);

        // Back-to-back streaming reads of addresses 0..7
        for (int i = 0; i < 8; i++) begin
            vals[i] = 21'(i * 32'h11111 + 3);
            wr(10'(i), vals[i], 3'b000, vals[i]);
        end
        for (int i = 0; i < 8; i++) begin
            NCE = 1'b0; NWRT = 1'b1; {RA, CA} = 10'(i);
            tick();
            exp_do[0] = vals[i]; exp_do[2] = vals[i];
            if (i > 0) begin
                exp_do[1] = vals[i-1]; exp_do[3] = vals[i-1];
                chk_out("stream", 4'b1111);
            end else begin
                chk_out("stream_first", 4'b0101);
            end
            $display("stream addr=%0d do_lat1=%06h do_lat2=%06h", i, do_w[0], do_w[1]);
        end
        NCE = 1'b1;
        tick();
        exp_do[1] = vals[7]; exp_do[3] = vals[7];
        chk_out("stream_last", 4'b1010);

        // Reset with a read still in the latency-2 pipeline
        NCE = 1'b0; NWRT = 1'b1; {RA, CA} = 10'd0;
        tick();
        exp_do[0] = vals[0]; exp_do[2] = vals[0];
        chk_out("mid_a", 4'b0101);
        {RA, CA} = 10'd1;
        tick();
        exp_do[0] = vals[1]; exp_do[2] = vals[1];
        exp_do[1] = vals[0]; exp_do[3] = vals[0];
        chk_out("mid_b", 4'b1111);
        NCE = 1'b1; RST = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) exp_do[i] = '0;
        chk_out("rst_flush", 4'b0000);
        chk_flag("rst_flush", 1'b1, 1'b0);
        RST = 1'b0;
        tick();
        chk_out("post_rst", 4'b0000);
        $display("reset mid-stream do=%06h dov=%0b", do_w[1], dov_w[1]);

        // Restart the sweep 300 cycles in, then inject a rejected write
        repeat (299) tick();
        chk_flag("pre_restart", 1'b1, 1'b0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        sweep(2000, 1'b1);
        chk("restart_len", 0, 32'(cnt), 32'd1024);
        chk_flag("restart_done", 1'b0, 1'b0);
        rd(10'd5, INIT);
        rd(10'd3, INIT);
        rd(10'h155, INIT);
        rd(10'd1023, INIT);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
